video_shifter: RTL



---
 rtl/video_shifter_pkg.sv | 6 +
 rtl/edge_detect.sv | 25 ++
 rtl/video_shifter.sv | 102 ++++++++++
 3 files changed

// File: rtl/video_shifter_pkg.sv
// Shared constants for the video_shifter pixel serializer.
package video_shifter_pkg;
    localparam int GLYPH_W          = 8;
    localparam int ACTIVE_DELAY_MIN = 1;
    localparam int ACTIVE_DELAY_MAX = 3;
endpackage

// File: rtl/edge_detect.sv
// One-bit input sampler with rise/fall detection against the previous sample.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic cur;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur  <= 1'b0;
            prev <= 1'b0;
        end else begin
            cur  <= din;
            prev <= cur;
        end
    end

    // Cleared history makes an input held high across reset count as a rise.
    assign rise = cur & ~prev;
    assign fall = ~cur & prev;
endmodule

// File: rtl/video_shifter.sv
// Pixel serializer: latches char/glyph from the shared bus, shifts one bit per pixel,
// applies reverse video and delayed active-area blanking.
module video_shifter
    import video_shifter_pkg::*;
#(
    parameter int ACTIVE_DELAY  = 1,
    parameter bit INVERT_OUTPUT = 1'b0
) (
    input  logic               clk16,
    input  logic               reset,
    input  logic               pixel_clk,
    input  logic               char_clk,
    input  logic               h_active,
    input  logic               v_active,
    input  logic               video_ram_strobe,
    input  logic               video_rom_strobe,
    input  logic [GLYPH_W-1:0] data_in,
    output logic               video,
    output logic               glyph_miss
);
    if (ACTIVE_DELAY < ACTIVE_DELAY_MIN || ACTIVE_DELAY > ACTIVE_DELAY_MAX) begin : g_bad_delay
        $error("video_shifter: ACTIVE_DELAY out of range 1..3");
    end

    logic pix_rise, pix_fall, char_rise, char_fall;
    logic ram_rise, ram_fall, rom_rise, rom_fall;

    edge_detect u_pix  (.clk(clk16), .rst(reset), .din(pixel_clk),        .rise(pix_rise),  .fall(pix_fall));
    edge_detect u_char (.clk(clk16), .rst(reset), .din(char_clk),         .rise(char_rise), .fall(char_fall));
    edge_detect u_ram  (.clk(clk16), .rst(reset), .din(video_ram_strobe), .rise(ram_rise),  .fall(ram_fall));
    edge_detect u_rom  (.clk(clk16), .rst(reset), .din(video_rom_strobe), .rise(rom_rise),  .fall(rom_fall));

    logic [GLYPH_W-1:0] data_q;
    logic               hv_q;
    logic [GLYPH_W-1:0] char_q;
    logic [GLYPH_W-1:0] glyph_q;
    logic               glyph_valid;
    logic [GLYPH_W-1:0] shift;
    logic               rev;
    logic [ACTIVE_DELAY-1:0] dl;
    logic [ACTIVE_DELAY:0]   dl_nxt;
    logic               act;
    logic               pix;
    logic               load;

    assign load   = char_rise;
    assign dl_nxt = {dl, hv_q};
    assign act    = dl[ACTIVE_DELAY-1];
    assign pix    = act & (shift[GLYPH_W-1] ^ rev);

    // Bus data and display enables are sampled alongside the strobes so they line up.
    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            hv_q   <= 1'b0;
        end else begin
            data_q <= data_in;
            hv_q   <= h_active & v_active;
        end
    end

    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            char_q  <= '0;
            glyph_q <= '0;
        end else begin
            if (ram_fall) char_q  <= data_q;
            if (rom_fall) glyph_q <= data_q;
        end
    end

    // A ROM fall coinciding with a load re-arms glyph_valid for the next character.
    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            shift       <= '0;
            rev         <= 1'b0;
            dl          <= '0;
            glyph_valid <= 1'b0;
            glyph_miss  <= 1'b0;
        end else begin
            glyph_miss <= 1'b0;
            if (load) begin
                shift       <= glyph_q;
                rev         <= char_q[GLYPH_W-1];
                dl          <= dl_nxt[ACTIVE_DELAY-1:0];
                glyph_miss  <= ~glyph_valid;
                glyph_valid <= 1'b0;
            end else if (pix_rise) begin
                shift <= {shift[GLYPH_W-2:0], 1'b0};
            end
            if (rom_fall) glyph_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) video <= INVERT_OUTPUT;
        else       video <= pix ^ INVERT_OUTPUT;
    end

    logic unused_bits;
    assign unused_bits = ^{pix_fall, char_fall, ram_rise, rom_rise, char_q[GLYPH_W-2:0]};
endmodule
